// File: rtl/cpu64_l1i_ctrl.sv
// L1 instruction cache sequencer: tag lookup, round-robin victim refill and
// invalidate-all serialisation for the 8-way, 64-set, 64 B-line arrays.
module cpu64_l1i_ctrl (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          fetch_req_valid_i,
    output logic          fetch_req_ready_o,
    input  logic [63:0]   fetch_addr_i,
    output logic          fetch_resp_valid_o,
    output logic [63:0]   fetch_resp_data_o,
    input  logic          inval_req_i,
    output logic          inval_done_o,
    output logic          mem_req_valid_o,
    input  logic          mem_req_ready_i,
    output logic [63:0]   mem_req_addr_o,
    input  logic          mem_rvalid_i,
    input  logic [63:0]   mem_rdata_i,
    output logic [5:0]    arr_index_o,
    output logic [2:0]    arr_word_sel_o,
    output logic [2:0]    arr_way_sel_o,
    output logic          arr_write_en_o,
    output logic          arr_set_valid_o,
    output logic [51:0]   arr_tag_o,
    output logic [63:0]   arr_wdata_o,
    output logic          arr_invalidate_all_o,
    input  logic [511:0]  arr_rdata_way_flat_i,
    input  logic [415:0]  arr_tag_way_flat_i,
    input  logic [7:0]    arr_valid_way_i
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_REFILL   = 3'd3,
        S_INVAL    = 3'd4
    } state_e;

    state_e       state_r, state_s;
    logic [63:3]  addr_r;
    logic         inval_pend_r;
    logic [2:0]   rr_ptr_r [64];
    logic [2:0]   victim_r;
    logic [2:0]   beat_r;
    logic         refill_done_r;

    logic         resp_valid_r, inval_done_r, mem_req_valid_r;
    logic [63:0]  resp_data_r, mem_req_addr_r, arr_wdata_r;
    logic [5:0]   arr_index_r;
    logic [2:0]   arr_word_sel_r, arr_way_sel_r;
    logic         arr_write_en_r, arr_set_valid_r, arr_inv_all_r;
    logic [51:0]  arr_tag_r;

    logic [7:0]   hit_s;
    logic         hit_any_s, inv_any_s;
    logic [2:0]   hit_way_s, victim_s;
    logic [63:0]  hit_data_s;
    logic         unused_s;

    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = vec[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    // Per-way tag compare against the latched fetch tag
    always_comb begin
        hit_s = 8'd0;
        for (int w = 0; w < 8; w++) begin
            hit_s[w] = arr_valid_way_i[w] && (arr_tag_way_flat_i[52*w +: 52] == addr_r[63:12]);
        end
    end

    assign hit_any_s  = |hit_s;
    assign hit_way_s  = lowest_set(hit_s);
    assign hit_data_s = arr_rdata_way_flat_i[{hit_way_s, 6'd0} +: 64];
    // Invalid ways are filled first; round-robin only once the set is full
    assign inv_any_s  = ~&arr_valid_way_i;
    assign victim_s   = inv_any_s ? lowest_set(~arr_valid_way_i) : rr_ptr_r[addr_r[11:6]];
    assign unused_s   = ^fetch_addr_i[2:0];

    assign fetch_req_ready_o = (state_r == S_IDLE) && !inval_pend_r && !inval_req_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (inval_pend_r || inval_req_i) begin
                    state_s = S_INVAL;
                end else if (fetch_req_valid_i) begin
                    state_s = S_LOOKUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOOKUP:   state_s = hit_any_s ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ: state_s = mem_req_ready_i ? S_REFILL : S_MISS_REQ;
            S_REFILL:   state_s = refill_done_r ? S_LOOKUP : S_REFILL;
            S_INVAL:    state_s = S_IDLE;
            default:    state_s = S_IDLE;
        endcase
    end

    // Datapath, replacement pointers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r          <= 61'd0;
            inval_pend_r    <= 1'b0;
            victim_r        <= 3'd0;
            beat_r          <= 3'd0;
            refill_done_r   <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= 64'd0;
            inval_done_r    <= 1'b0;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= 64'd0;
            arr_index_r     <= 6'd0;
            arr_word_sel_r  <= 3'd0;
            arr_way_sel_r   <= 3'd0;
            arr_write_en_r  <= 1'b0;
            arr_set_valid_r <= 1'b0;
            arr_tag_r       <= 52'd0;
            arr_wdata_r     <= 64'd0;
            arr_inv_all_r   <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                rr_ptr_r[i] <= 3'd0;
            end
        end else begin
            resp_valid_r    <= 1'b0;
            inval_done_r    <= 1'b0;
            arr_write_en_r  <= 1'b0;
            arr_set_valid_r <= 1'b0;
            arr_inv_all_r   <= 1'b0;
            inval_pend_r    <= inval_pend_r | inval_req_i;
            case (state_r)
                S_IDLE: begin
                    if (inval_pend_r || inval_req_i) begin
                        inval_pend_r  <= 1'b0;
                        arr_inv_all_r <= 1'b1;
                    end else if (fetch_req_valid_i) begin
                        addr_r         <= fetch_addr_i[63:3];
                        arr_index_r    <= fetch_addr_i[11:6];
                        arr_word_sel_r <= fetch_addr_i[5:3];
                    end
                end
                S_LOOKUP: begin
                    if (hit_any_s) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= hit_data_s;
                    end else begin
                        victim_r        <= victim_s;
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= {addr_r[63:6], 6'd0};
                        if (!inv_any_s) begin
                            rr_ptr_r[addr_r[11:6]] <= rr_ptr_r[addr_r[11:6]] + 3'd1;
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_r <= 1'b0;
                        beat_r          <= 3'd0;
                        refill_done_r   <= 1'b0;
                    end
                end
                S_REFILL: begin
                    // One extra cycle after beat 7 lets the last write land before replay
                    if (refill_done_r) begin
                        refill_done_r  <= 1'b0;
                        arr_word_sel_r <= addr_r[5:3];
                    end else if (mem_rvalid_i) begin
                        arr_write_en_r  <= 1'b1;
                        arr_way_sel_r   <= victim_r;
                        arr_word_sel_r  <= beat_r;
                        arr_tag_r       <= addr_r[63:12];
                        arr_wdata_r     <= mem_rdata_i;
                        arr_set_valid_r <= (beat_r == 3'd7);
                        refill_done_r   <= (beat_r == 3'd7);
                        beat_r          <= beat_r + 3'd1;
                    end
                end
                S_INVAL: begin
                    inval_done_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign fetch_resp_valid_o   = resp_valid_r;
    assign fetch_resp_data_o    = resp_data_r;
    assign inval_done_o         = inval_done_r;
    assign mem_req_valid_o      = mem_req_valid_r;
    assign mem_req_addr_o       = mem_req_addr_r;
    assign arr_index_o          = arr_index_r;
    assign arr_word_sel_o       = arr_word_sel_r;
    assign arr_way_sel_o        = arr_way_sel_r;
    assign arr_write_en_o       = arr_write_en_r;
    assign arr_set_valid_o      = arr_set_valid_r;
    assign arr_tag_o            = arr_tag_r;
    assign arr_wdata_o          = arr_wdata_r;
    assign arr_invalidate_all_o = arr_inv_all_r;

endmodule

// File: tb/tb_cpu64_l1i_ctrl.sv
// Self-checking bench for cpu64_l1i_ctrl: behavioural cache array, response and
// array-write scoreboards, table-driven fetch vectors plus invalidate/reset sequences.
module tb_cpu64_l1i_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          fetch_req_valid_i, fetch_req_ready_o;
    logic [63:0]   fetch_addr_i;
    logic          fetch_resp_valid_o;
    logic [63:0]   fetch_resp_data_o;
    logic          inval_req_i, inval_done_o;
    logic          mem_req_valid_o, mem_req_ready_i;
    logic [63:0]   mem_req_addr_o;
    logic          mem_rvalid_i;
    logic [63:0]   mem_rdata_i;
    logic [5:0]    arr_index_o;
    logic [2:0]    arr_word_sel_o, arr_way_sel_o;
    logic          arr_write_en_o, arr_set_valid_o, arr_invalidate_all_o;
    logic [51:0]   arr_tag_o;
    logic [63:0]   arr_wdata_o;
    logic [511:0]  rdata_flat;
    logic [415:0]  tag_flat;
    logic [7:0]    valid_vec;

    cpu64_l1i_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .fetch_req_valid_i(fetch_req_valid_i), .fetch_req_ready_o(fetch_req_ready_o),
        .fetch_addr_i(fetch_addr_i),
        .fetch_resp_valid_o(fetch_resp_valid_o), .fetch_resp_data_o(fetch_resp_data_o),
        .inval_req_i(inval_req_i), .inval_done_o(inval_done_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o),
        .arr_way_sel_o(arr_way_sel_o), .arr_write_en_o(arr_write_en_o),
        .arr_set_valid_o(arr_set_valid_o), .arr_tag_o(arr_tag_o),
        .arr_wdata_o(arr_wdata_o), .arr_invalidate_all_o(arr_invalidate_all_o),
        .arr_rdata_way_flat_i(rdata_flat), .arr_tag_way_flat_i(tag_flat),
        .arr_valid_way_i(valid_vec)
    );

    typedef struct {
        logic [63:0] addr;
        logic        miss;
        logic [2:0]  victim;
        logic [63:0] base;
        logic [63:0] exp_data;
        int          req_stall;
        int          beat_gap;
        int          inval_beat;
    } vec_t;

    typedef struct {
        logic [2:0]  way;
        logic [2:0]  word;
        logic [5:0]  idx;
        logic [51:0] tag;
        logic [63:0] data;
        logic        sv;
    } wr_t;

    // Behavioural array contents
    bit [51:0] tag_m  [8][64];
    bit        val_m  [8][64];
    bit [63:0] data_m [8][64][8];

    bit          pre_en = 1'b0;
    int          pre_way, pre_idx;
    logic [51:0] pre_tag;

    logic [63:0] exp_q[$];
    wr_t         wr_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int resp_seen = 0, resp_cyc = 0, inv_cnt = 0, inv_cyc = 0, done_cnt = 0, done_cyc = 0;
    bit mem_seen = 1'b0;

    function automatic logic [63:0] pdata(input int w, input int i, input int k);
        return 64'hD000_0000_0000_0000 | (64'(w) << 16) | (64'(i) << 8) | 64'(k);
    endfunction

    always_comb begin
        rdata_flat = 512'd0;
        tag_flat   = 416'd0;
        valid_vec  = 8'd0;
        for (int w = 0; w < 8; w++) begin
            rdata_flat[64*w +: 64] = data_m[w][arr_index_o][arr_word_sel_o];
            tag_flat[52*w +: 52]   = tag_m[w][arr_index_o];
            valid_vec[w]           = val_m[w][arr_index_o];
        end
    end

    always @(posedge clk) begin
        if (pre_en) begin
            tag_m[pre_way][pre_idx] <= pre_tag;
            val_m[pre_way][pre_idx] <= 1'b1;
            for (int k = 0; k < 8; k++) data_m[pre_way][pre_idx][k] <= pdata(pre_way, pre_idx, k);
        end else if (arr_invalidate_all_o) begin
            for (int w = 0; w < 8; w++)
                for (int i = 0; i < 64; i++) val_m[w][i] <= 1'b0;
        end else if (arr_write_en_o) begin
            tag_m[arr_way_sel_o][arr_index_o] <= arr_tag_o;
            val_m[arr_way_sel_o][arr_index_o] <= arr_set_valid_o;
            data_m[arr_way_sel_o][arr_index_o][arr_word_sel_o] <= arr_wdata_o;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t w;
        logic [63:0] e;
        if (fetch_resp_valid_o) begin
            resp_seen++;
            resp_cyc = cyc;
            chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_data", fetch_resp_data_o, e);
            end
        end
        if (arr_write_en_o) begin
            chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                chk("wr_way", 64'(arr_way_sel_o), 64'(w.way));
                chk("wr_word", 64'(arr_word_sel_o), 64'(w.word));
                chk("wr_index", 64'(arr_index_o), 64'(w.idx));
                chk("wr_tag", 64'(arr_tag_o), 64'(w.tag));
                chk("wr_data", arr_wdata_o, w.data);
                chk("wr_set_valid", 64'(arr_set_valid_o), 64'(w.sv));
            end
        end
        if (mem_req_valid_o) mem_seen = 1'b1;
        if (arr_invalidate_all_o) begin inv_cnt++; inv_cyc = cyc; end
        if (inval_done_o) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic preload(input int w, input int i, input logic [51:0] t);
        pre_en = 1'b1; pre_way = w; pre_idx = i; pre_tag = t;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(fetch_req_ready_o), 64'd1);
        chk({tag, "_resp_valid"}, 64'(fetch_resp_valid_o), 64'd0);
        chk({tag, "_resp_data"}, fetch_resp_data_o, 64'd0);
        chk({tag, "_mreq_valid"}, 64'(mem_req_valid_o), 64'd0);
        chk({tag, "_mreq_addr"}, mem_req_addr_o, 64'd0);
        chk({tag, "_wr_en"}, 64'(arr_write_en_o), 64'd0);
        chk({tag, "_inv_all"}, 64'(arr_invalidate_all_o), 64'd0);
        chk({tag, "_inv_done"}, 64'(inval_done_o), 64'd0);
    endtask

    task automatic accept(input logic [63:0] addr);
        int n;
        fetch_addr_i = addr;
        fetch_req_valid_i = 1'b1;
        n = 0;
        while (!fetch_req_ready_o && n < 50) begin tick(); n++; end
        chk("accept_ready", 64'(fetch_req_ready_o), 64'd1);
    endtask

    task automatic do_fetch(input vec_t v);
        int n, r0;
        logic [63:0] a0;
        wr_t w;
        accept(v.addr);
        exp_q.push_back(v.exp_data);
        mem_seen = 1'b0;
        r0 = resp_seen;
        tick();
        fetch_req_valid_i = 1'b0;
        if (v.miss) begin
            tick();
            chk("mreq_at_T2", 64'(mem_req_valid_o), 64'd1);
            chk("mreq_addr", mem_req_addr_o, {v.addr[63:6], 6'd0});
            a0 = mem_req_addr_o;
            for (int s = 0; s < v.req_stall; s++) begin
                tick();
                chk("mreq_hold_valid", 64'(mem_req_valid_o), 64'd1);
                chk("mreq_hold_addr", mem_req_addr_o, a0);
            end
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            chk("mreq_drop", 64'(mem_req_valid_o), 64'd0);
            for (int k = 0; k < 8; k++) begin
                for (int g = 0; g < v.beat_gap; g++) tick();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.base + 64'(k);
                if (k == v.inval_beat) inval_req_i = 1'b1;
                w.way = v.victim; w.word = 3'(k); w.idx = v.addr[11:6];
                w.tag = v.addr[63:12]; w.data = v.base + 64'(k); w.sv = (k == 7);
                wr_q.push_back(w);
                tick();
                mem_rvalid_i = 1'b0;
                inval_req_i  = 1'b0;
            end
            n = 0;
            while (resp_seen == r0 && n < 20) begin tick(); n++; end
            chk("replay_lat", 64'(n), 64'd2);
        end else begin
            n = 0;
            while (resp_seen == r0 && n < 20) begin tick(); n++; end
            chk("hit_lat", 64'(n), 64'd1);
            chk("hit_no_mreq", 64'(mem_seen), 64'd0);
        end
    endtask

    vec_t vecs[13];
    vec_t hv;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, r0, i0, d0;
        vecs[0] = '{addr: 64'h1148, miss: 1'b0, victim: 3'd0, base: 64'd0,
                    exp_data: pdata(3, 5, 1), req_stall: 0, beat_gap: 0, inval_beat: -1};
        vecs[1] = '{addr: 64'h2000, miss: 1'b1, victim: 3'd0, base: 64'hA0,
                    exp_data: 64'hA0, req_stall: 0, beat_gap: 0, inval_beat: -1};
        vecs[2] = '{addr: 64'h3050, miss: 1'b1, victim: 3'd0, base: 64'hB0,
                    exp_data: 64'hB2, req_stall: 5, beat_gap: 2, inval_beat: -1};
        for (int i = 0; i < 9; i++) begin
            vecs[3+i] = '{addr: (64'(52'h200 + 52'(i)) << 12) | (64'd9 << 6), miss: 1'b1,
                          victim: 3'(i), base: 64'h5A00_0000_0000_0000 | (64'(i) << 8),
                          exp_data: 64'h5A00_0000_0000_0000 | (64'(i) << 8),
                          req_stall: 0, beat_gap: 0, inval_beat: -1};
        end
        vecs[12] = '{addr: (64'h208 << 12) | (64'd9 << 6) | (64'd3 << 3), miss: 1'b0, victim: 3'd0,
                     base: 64'd0, exp_data: 64'h5A00_0000_0000_0803, req_stall: 0, beat_gap: 0,
                     inval_beat: -1};

        rst_i = 1'b1; fetch_req_valid_i = 1'b0; fetch_addr_i = 64'd0; inval_req_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
        tick();
        preload(3, 5, 52'h1);
        for (int w = 0; w < 8; w++) preload(w, 9, 52'h100 + 52'(w));
        rst_i = 1'b0;
        tick();
        check_reset_outputs("por");

        for (int i = 0; i < 13; i++) do_fetch(vecs[i]);

        // Invalidate and fetch in the same IDLE cycle: invalidate wins
        fetch_addr_i = 64'h1148; fetch_req_valid_i = 1'b1; inval_req_i = 1'b1;
        #1;
        chk("inv_win_ready", 64'(fetch_req_ready_o), 64'd0);
        c = cyc; r0 = resp_seen; i0 = inv_cnt; d0 = done_cnt;
        tick();
        fetch_req_valid_i = 1'b0; inval_req_i = 1'b0;
        tick(); tick(); tick();
        chk("inv_all_cyc", 64'(inv_cyc), 64'(c + 1));
        chk("inv_done_cyc", 64'(done_cyc), 64'(c + 2));
        chk("inv_all_once", 64'(inv_cnt - i0), 64'd1);
        chk("inv_done_once", 64'(done_cnt - d0), 64'd1);
        chk("inv_no_resp", 64'(resp_seen), 64'(r0));

        hv = '{addr: 64'h1148, miss: 1'b1, victim: 3'd0, base: 64'hF0, exp_data: 64'hF1,
               req_stall: 0, beat_gap: 0, inval_beat: -1};
        do_fetch(hv);

        // Invalidate pulsed mid-refill is deferred until after the response
        i0 = inv_cnt;
        hv = '{addr: 64'h4000, miss: 1'b1, victim: 3'd0, base: 64'hC0, exp_data: 64'hC0,
               req_stall: 0, beat_gap: 0, inval_beat: 3};
        do_fetch(hv);
        chk("refill_inv_none_yet", 64'(inv_cnt - i0), 64'd0);
        tick(); tick(); tick();
        chk("refill_inv_cyc", 64'(inv_cyc), 64'(resp_cyc + 1));
        chk("refill_done_cyc", 64'(done_cyc), 64'(resp_cyc + 2));
        chk("refill_inv_once", 64'(inv_cnt - i0), 64'd1);
        hv = '{addr: 64'h4000, miss: 1'b1, victim: 3'd0, base: 64'hD0, exp_data: 64'hD0,
               req_stall: 0, beat_gap: 0, inval_beat: -1};
        do_fetch(hv);

        // Reset at beat 4 of a refill into way 1
        accept(64'h5000);
        tick();
        fetch_req_valid_i = 1'b0;
        tick();
        chk("rst_mreq", 64'(mem_req_valid_o), 64'd1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_t w;
            mem_rvalid_i = 1'b1; mem_rdata_i = 64'h70 + 64'(k);
            w.way = 3'd1; w.word = 3'(k); w.idx = 6'd0; w.tag = 52'h5;
            w.data = 64'h70 + 64'(k); w.sv = 1'b0;
            wr_q.push_back(w);
            tick();
        end
        rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h74;
        tick();
        rst_i = 1'b0; mem_rvalid_i = 1'b0;
        check_reset_outputs("rst_mid");
        hv = '{addr: 64'h5000, miss: 1'b1, victim: 3'd1, base: 64'hE0, exp_data: 64'hE0,
               req_stall: 0, beat_gap: 0, inval_beat: -1};
        do_fetch(hv);

        tick(); tick();
        chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
